// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator.
package bounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        BOUNCE = 1'b1
    } state_t;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One right-shift step of the Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    endfunction

endpackage

// File: rtl/bounce_emulator_lfsr.sv
// 16-bit Galois LFSR that steps only when asked, so the burst pattern
// depends solely on how many random cycles have been emitted since reset.
module lfsr_galois16
    import bounce_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // Load the seed on reset, otherwise step on request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= seed;
        end else if (adv) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/bounce_emulator.sv
// Turns a clean switch level into a bouncing one: every accepted level
// change emits BOUNCE_CYCLES-1 pseudo-random cycles, then the final level.
module bounce_emulator
    import bounce_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 8,
    parameter logic [15:0] SEED          = DEFAULT_SEED
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clean_in,
    output logic noisy_out,
    output logic busy,
    output logic settled
);

    localparam int                CNT_W    = $clog2(BOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0]       SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    state_t           r_state;
    logic             r_noisy;
    logic             r_settled;
    logic             r_level_q;
    logic             r_target;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic             w_noisy_nxt;
    logic             w_settled_nxt;
    logic             w_level_nxt;
    logic             w_target_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_adv;
    logic [15:0]      w_lfsr;
    // Only bit 0 is the output tap; the upper bits just carry LFSR state.
    logic [14:0]      w_lfsr_unused;

    assign w_lfsr_unused = w_lfsr[15:1];

    lfsr_galois16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (w_adv),
        .seed  (SEED_EFF),
        .q     (w_lfsr)
    );

    // Next-state and output decisions; abort beats retarget beats finish.
    always_comb begin
        w_state_nxt   = r_state;
        w_noisy_nxt   = r_noisy;
        w_settled_nxt = 1'b0;
        w_level_nxt   = r_level_q;
        w_target_nxt  = r_target;
        w_cnt_nxt     = r_cnt;
        w_adv         = 1'b0;
        case (r_state)
            STABLE: begin
                if (!enable) begin
                    w_noisy_nxt = clean_in;
                    w_level_nxt = clean_in;
                end else if (clean_in != r_level_q) begin
                    w_target_nxt = clean_in;
                    w_noisy_nxt  = clean_in;
                    w_cnt_nxt    = CNT_LOAD;
                    w_state_nxt  = BOUNCE;
                end
            end
            BOUNCE: begin
                if (!enable) begin
                    w_noisy_nxt = clean_in;
                    w_level_nxt = clean_in;
                    w_state_nxt = STABLE;
                end else if (clean_in != r_target) begin
                    w_target_nxt = clean_in;
                    w_noisy_nxt  = clean_in;
                    w_cnt_nxt    = CNT_LOAD;
                end else if (r_cnt == CNT_ONE) begin
                    w_noisy_nxt   = r_target;
                    w_level_nxt   = r_target;
                    w_settled_nxt = 1'b1;
                    w_state_nxt   = STABLE;
                end else begin
                    w_noisy_nxt = w_lfsr[0];
                    w_adv       = 1'b1;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            default: w_state_nxt = STABLE;
        endcase
    end

    // State, counter and output registers; reset aborts any burst at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= STABLE;
            r_noisy   <= 1'b0;
            r_settled <= 1'b0;
            r_level_q <= 1'b0;
            r_target  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_noisy   <= w_noisy_nxt;
            r_settled <= w_settled_nxt;
            r_level_q <= w_level_nxt;
            r_target  <= w_target_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign noisy_out = r_noisy;
    assign busy      = (r_state == BOUNCE);
    assign settled   = r_settled;

endmodule

// File: tb/tb_bounce_emulator.sv
// Self-checking bench for bounce_emulator: a reference model of the burst
// rules checked every cycle, plus literal expectations for known scenarios.
module tb_bounce_emulator;

    localparam int BC = 8;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic clean_in;
    logic noisy_out, busy, settled;
    logic noisy1, busy1, settled1;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    bounce_emulator #(.BOUNCE_CYCLES(BC), .SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clean_in(clean_in),
        .noisy_out(noisy_out), .busy(busy), .settled(settled)
    );

    bounce_emulator #(.BOUNCE_CYCLES(1), .SEED(16'hACE1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .clean_in(clean_in),
        .noisy_out(noisy1), .busy(busy1), .settled(settled1)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] poly_step(input logic [15:0] q);
        logic fb;
        fb = q[0];
        q  = q >> 1;
        if (fb) q = q ^ 16'hB400;
        return q;
    endfunction

    int          edge_no = 0;
    int          m_end   = 0;
    bit          m_burst = 0;
    logic        m_noisy = 0, m_settled = 0, m_level = 0, m_target = 0;
    logic [15:0] m_lfsr  = 16'hACE1;

    // A burst is a deadline: the final level lands exactly BC edges after
    // the latest (re)trigger; in between each edge emits one LFSR bit.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_burst = 0; m_noisy = 0; m_settled = 0;
            m_level = 0; m_target = 0; m_lfsr = 16'hACE1;
        end else begin
            edge_no++;
            m_settled = 0;
            if (!enable) begin
                m_noisy = clean_in; m_level = clean_in; m_burst = 0;
            end else if (!m_burst) begin
                if (clean_in != m_level) begin
                    m_target = clean_in; m_noisy = clean_in;
                    m_burst = 1; m_end = edge_no + BC;
                end
            end else if (clean_in != m_target) begin
                m_target = clean_in; m_noisy = clean_in; m_end = edge_no + BC;
            end else if (edge_no == m_end) begin
                m_noisy = m_target; m_level = m_target;
                m_settled = 1; m_burst = 0;
            end else begin
                m_noisy = m_lfsr[0];
                m_lfsr  = poly_step(m_lfsr);
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            check1("model_noisy", noisy_out, m_noisy);
            check1("model_busy", busy, m_burst);
            check1("model_settled", settled, m_settled);
        end
    end

    // ---------------- 4-sample debounce used for loopback ----------------
    logic [2:0] db_sr;
    logic       db_out;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            db_sr  <= 3'b000;
            db_out <= 1'b0;
        end else begin
            if ({db_sr, noisy_out} == 4'b1111) db_out <= 1'b1;
            else if ({db_sr, noisy_out} == 4'b0000) db_out <= 1'b0;
            db_sr <= {db_sr[1:0], noisy_out};
        end
    end

    int gaps [20];

    task automatic run_loop(output logic [31:0] hash);
        hash = 32'd5381;
        #1 reset = 1'b1;
        step();
        reset = 1'b0;
        enable = 1'b1;
        clean_in = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            clean_in = ~clean_in;
            for (int w = 1; w <= gaps[i]; w++) begin
                step();
                hash = (hash * 33) ^ {31'd0, noisy_out};
                if (w == BC + 6) check1("loop_debounce", db_out, clean_in);
            end
        end
    endtask

    bit gold [9];
    int cnt_s;
    logic [31:0] h1, h2;

    initial begin
        gold = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        reset = 1'b1; enable = 1'b1; clean_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        run_cmp = 1'b1;

        // reset state
        check1("rst_noisy", noisy_out, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_settled", settled, 1'b0);
        check32("rst_lfsr", 32'(dut.u_lfsr.q), 32'hACE1);
        repeat (3) step();

        // basic burst with golden LFSR waveform; BC=1 instance alongside
        clean_in = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            check1("burst_noisy", noisy_out, gold[k]);
            check1("burst_busy", busy, (k < 8));
            check1("burst_settled", settled, (k == 8));
            if (k == 0) begin
                check1("bc1_noisy_t0", noisy1, 1'b1);
                check1("bc1_busy_t0", busy1, 1'b1);
            end
            if (k == 1) begin
                check1("bc1_busy_t1", busy1, 1'b0);
                check1("bc1_settled_t1", settled1, 1'b1);
                check1("bc1_noisy_t1", noisy1, 1'b1);
            end
            if (k == 2) check1("bc1_settled_t2", settled1, 1'b0);
        end
        step();
        check1("burst_settled_end", settled, 1'b0);
        check32("burst_lfsr_end", 32'(dut.u_lfsr.q), 32'hED89);
        check32("bc1_lfsr_idle", 32'(dut1.u_lfsr.q), 32'hACE1);

        // reset in the middle of a burst
        clean_in = 1'b0;
        repeat (5) step();
        #1 reset = 1'b1;
        #1;
        check1("midrst_noisy", noisy_out, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_settled", settled, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        check32("midrst_lfsr", 32'(dut.u_lfsr.q), 32'hACE1);
        cnt_s = 0;
        for (int j = 0; j < 12; j++) begin
            step();
            if (settled) cnt_s++;
        end
        check32("midrst_no_settle", 32'(cnt_s), 32'd0);

        // pass-through
        enable = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) clean_in = ~clean_in;
            step();
            check1("pass_noisy", noisy_out, clean_in);
            check1("pass_busy", busy, 1'b0);
            check1("pass_settled", settled, 1'b0);
        end
        enable = 1'b1;
        repeat (3) step();

        // retarget: short pulse reloads the counter
        clean_in = 1'b1;
        repeat (3) step();
        clean_in = 1'b0;
        step();
        check1("retgt_noisy", noisy_out, 1'b0);
        check1("retgt_busy", busy, 1'b1);
        for (int j = 1; j <= 10; j++) begin
            step();
            check1("retgt_settled", settled, (j == 8));
            check1("retgt_busy_run", busy, (j < 8));
        end
        check1("retgt_final", noisy_out, 1'b0);
        check1("retgt_level", dut.r_level_q, 1'b0);

        // abort by dropping enable
        clean_in = 1'b1;
        repeat (2) step();
        enable = 1'b0;
        step();
        check1("abort_busy", busy, 1'b0);
        check1("abort_noisy", noisy_out, 1'b1);
        clean_in = 1'b0;
        cnt_s = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (settled) cnt_s++;
        end
        check1("abort_follow", noisy_out, 1'b0);
        check32("abort_no_settle", 32'(cnt_s), 32'd0);
        enable = 1'b1;

        // randomized stimulus, checked by the model every cycle
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 5) == 0) clean_in = ~clean_in;
            step();
        end

        // loopback into debounce, twice with identical stimulus
        enable = 1'b1;
        for (int i = 0; i < 20; i++) gaps[i] = 16 + int'($urandom_range(0, 8));
        run_loop(h1);
        run_loop(h2);
        check32("loop_repeatable", h2, h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
